// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle MIPS main controller:
// FSM states, opcodes, aluop codes (also used by aluctrl) and mux select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_IEXEC,
        S_IWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Raw Moore control word; strobes are gated by mem_ready in the top.
    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_out_dec.sv
// Combinational decode of FSM state (and opcode, where it matters) into the
// raw datapath control word.
module mc_out_dec
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: assigning a full default first keeps every path driven, so no latch is inferred.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMM_SH;
                case (op)
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_XORI, OP_J: ;
                    default: begin
                        ctrl.illegal_op = 1'b1;
                        ctrl.instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.memtoreg   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req    = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.regdst     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_B;
                ctrl.aluop      = ALU_SUB;
                ctrl.pcsrc      = PC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_IEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                case (op)
                    OP_ORI:  ctrl.aluop = ALU_OR;
                    OP_XORI: ctrl.aluop = ALU_XOR;
                    default: ctrl.aluop = ALU_ADD;
                endcase
            end
            S_IWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc      = PC_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// next-state logic and mem_ready gating around the mc_out_dec decoder.
module mc_main_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t state_q, state_d;
    ctrl_t  ctrl;
    logic   ready_ok;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:               state_d = S_MEMADR;
                    OP_R:                       state_d = S_EXEC;
                    OP_BEQ:                     state_d = S_BRANCH;
                    OP_ADDI, OP_ORI, OP_XORI:   state_d = S_IEXEC;
                    OP_J:                       state_d = S_JUMP;
                    default:                    state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_out_dec u_out_dec (
        .state (state_q),
        .op    (op),
        .ctrl  (ctrl)
    );

    // Strobes in memory-access states only fire in the cycle the access completes.
    assign ready_ok = !ctrl.mem_req || mem_ready;

    always_comb begin
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 3'b000;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (rst_n) begin
            mem_req    = ctrl.mem_req;
            memwrite   = ctrl.memwrite & ready_ok;
            iord       = ctrl.iord;
            irwrite    = ctrl.irwrite & ready_ok;
            pcen       = (ctrl.pcwrite & ready_ok) | (ctrl.branch & zero);
            pcsrc      = ctrl.pcsrc;
            alusrca    = ctrl.alusrca;
            alusrcb    = ctrl.alusrcb;
            aluop      = ctrl.aluop;
            regdst     = ctrl.regdst;
            memtoreg   = ctrl.memtoreg;
            regwrite   = ctrl.regwrite;
            instr_done = ctrl.instr_done & ready_ok;
            illegal_op = ctrl.illegal_op;
        end
    end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: expected control words are queued as
// each cycle's stimulus is driven and compared when the outputs are sampled.
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, memwrite, iord, irwrite, pcen;
    logic [1:0] pcsrc, alusrcb;
    logic       alusrca;
    logic [2:0] aluop;
    logic       regdst, memtoreg, regwrite, instr_done, illegal_op;

    int total = 0;
    int bad   = 0;

    logic [17:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    mc_main_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .pcsrc      (pcsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .aluop      (aluop),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    // Word layout: mem_req memwrite iord irwrite pcen pcsrc[2] alusrca alusrcb[2]
    //              aluop[3] regdst memtoreg regwrite instr_done illegal_op
    function automatic logic [17:0] w(input logic mreq, input logic mwr, input logic io,
                                      input logic irw, input logic pce, input logic [1:0] psrc,
                                      input logic sa, input logic [1:0] sb, input logic [2:0] aop,
                                      input logic rd, input logic m2r, input logic rw,
                                      input logic done, input logic ill);
        return {mreq, mwr, io, irw, pce, psrc, sa, sb, aop, rd, m2r, rw, done, ill};
    endfunction

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", tag, got, want);
        end
    endtask

    task automatic step(input logic rn, input logic mr, input logic z, input logic [5:0] o,
                        input logic [17:0] e, input string tag);
        logic [17:0] obs;
        rst_n     = rn;
        mem_ready = mr;
        zero      = z;
        op        = o;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = {mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
               aluop, regdst, memtoreg, regwrite, instr_done, illegal_op};
        check(tag_q.pop_front(), obs, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [5:0] o, input int waits);
        for (int i = 0; i < waits; i++)
            step(1, 0, 0, o, w(1,0,0,0,0,2'b00,0,2'b01,3'b000,0,0,0,0,0), "fetch_wait");
        step(1, 1, 0, o, w(1,0,0,1,1,2'b00,0,2'b01,3'b000,0,0,0,0,0), "fetch");
        step(1, 1, 0, o, w(0,0,0,0,0,2'b00,0,2'b11,3'b000,0,0,0,0,0), "decode");
    endtask

    task automatic imm_op(input logic [5:0] o, input logic [2:0] aop, input string name);
        fetch_decode(o, 0);
        step(1, 1, 0, o, w(0,0,0,0,0,2'b00,1,2'b10,aop,0,0,0,0,0), {name, "_iexec"});
        step(1, 1, 0, o, w(0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,1,1,0), {name, "_iwb"});
    endtask

    task automatic beq(input logic z);
        fetch_decode(6'b000100, 0);
        step(1, 1, z, 6'b000100, w(0,0,0,0,z,2'b01,1,2'b00,3'b001,0,0,0,1,0), z ? "beq_taken" : "beq_not");
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = 6'b0;
        @(posedge clk);
        #1;
        step(0, 1, 1, 6'b000000, 18'd0, "reset0");
        step(0, 1, 1, 6'b000000, 18'd0, "reset1");

        // R-type add, then reset held 3 cycles starting mid-EXEC
        fetch_decode(6'b000000, 0);
        step(1, 1, 0, 6'b000000, w(0,0,0,0,0,2'b00,1,2'b00,3'b010,0,0,0,0,0), "r_exec");
        step(1, 1, 0, 6'b000000, w(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,1,1,0), "r_aluwb");
        fetch_decode(6'b000000, 0);
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 6'b000000, 18'd0, "reset_mid");
        step(1, 0, 0, 6'b000000, w(1,0,0,0,0,2'b00,0,2'b01,3'b000,0,0,0,0,0), "post_reset_fetch");
        step(1, 1, 0, 6'b000000, w(1,0,0,1,1,2'b00,0,2'b01,3'b000,0,0,0,0,0), "fetch");
        step(1, 1, 0, 6'b000000, w(0,0,0,0,0,2'b00,0,2'b11,3'b000,0,0,0,0,0), "decode");
        step(1, 1, 0, 6'b000000, w(0,0,0,0,0,2'b00,1,2'b00,3'b010,0,0,0,0,0), "r_exec");
        step(1, 1, 0, 6'b000000, w(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,1,1,0), "r_aluwb");

        // lw with two wait cycles in MEMRD and one in FETCH
        fetch_decode(6'b100011, 1);
        step(1, 1, 0, 6'b100011, w(0,0,0,0,0,2'b00,1,2'b10,3'b000,0,0,0,0,0), "lw_memadr");
        step(1, 0, 0, 6'b100011, w(1,0,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0), "lw_memrd_wait");
        step(1, 0, 0, 6'b100011, w(1,0,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0), "lw_memrd_wait");
        step(1, 1, 0, 6'b100011, w(1,0,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0), "lw_memrd");
        step(1, 1, 0, 6'b100011, w(0,0,0,0,0,2'b00,0,2'b00,3'b000,0,1,1,1,0), "lw_memwb");

        // sw with one wait cycle in MEMWR
        fetch_decode(6'b101011, 0);
        step(1, 1, 0, 6'b101011, w(0,0,0,0,0,2'b00,1,2'b10,3'b000,0,0,0,0,0), "sw_memadr");
        step(1, 0, 0, 6'b101011, w(1,0,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0), "sw_memwr_wait");
        step(1, 1, 0, 6'b101011, w(1,1,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,1,0), "sw_memwr");

        beq(1'b1);
        beq(1'b0);

        imm_op(6'b001000, 3'b000, "addi");
        imm_op(6'b001101, 3'b011, "ori");
        imm_op(6'b001110, 3'b100, "xori");

        fetch_decode(6'b000010, 0);
        step(1, 1, 0, 6'b000010, w(0,0,0,0,1,2'b10,0,2'b00,3'b000,0,0,0,1,0), "j_jump");

        step(1, 1, 0, 6'b111111, w(1,0,0,1,1,2'b00,0,2'b01,3'b000,0,0,0,0,0), "fetch");
        step(1, 1, 0, 6'b111111, w(0,0,0,0,0,2'b00,0,2'b11,3'b000,0,0,0,1,1), "illegal_decode");
        step(1, 1, 0, 6'b000000, w(1,0,0,1,1,2'b00,0,2'b01,3'b000,0,0,0,0,0), "illegal_refetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
